// File: rtl/position_pkg.sv
// Shared types and constants for the red-object position scanner.
package position_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FS,
      ACCUM,
      DECIDE,
      FILTER
   } scan_state_t;

   localparam int unsigned NUM_ZONES  = 5;
   localparam int unsigned ZONE_SHIFT = 7;

   localparam logic [2:0] POS_NONE = 3'd0;
   localparam logic [2:0] POS_Z1   = 3'd1;
   localparam logic [2:0] POS_Z2   = 3'd2;
   localparam logic [2:0] POS_Z3   = 3'd3;
   localparam logic [2:0] POS_Z4   = 3'd4;
   localparam logic [2:0] POS_Z5   = 3'd5;

   // Zone index of a pixel column: 128-column bands.
   function automatic logic [2:0] zone_of(input logic [10:0] x);
      return x[ZONE_SHIFT+2:ZONE_SHIFT];
   endfunction

endpackage

// File: rtl/zone_counter.sv
// Bank of saturating per-zone hit counters with a single read port.
module zone_counter
   import position_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   input  logic [2:0]  inc_idx,
   input  logic [2:0]  rd_idx,
   output logic [15:0] rd_cnt
);

   logic [15:0] cnt [NUM_ZONES];

   // Clear (optionally counting the same-cycle hit) or saturating increment.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
         if (rst) begin
            cnt[i] <= '0;
         end else if (clr) begin
            cnt[i] <= (inc && inc_idx == 3'(i)) ? 16'd1 : '0;
         end else if (inc && inc_idx == 3'(i) && cnt[i] != '1) begin
            cnt[i] <= cnt[i] + 16'd1;
         end
      end
   end

   // Read mux; out-of-range indices read as zero.
   always_comb begin
      rd_cnt = '0;
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
         if (rd_idx == 3'(i)) rd_cnt = cnt[i];
      end
   end

endmodule

// File: rtl/position_scan_ctrl.sv
// Per-frame red-hit histogram over 5 column zones, argmax decision and
// N-frame stability filter driving the reported position.
module position_scan_ctrl
   import position_pkg::*;
#(
   parameter int          H_ACTIVE      = 640,
   parameter int          V_ACTIVE      = 480,
   parameter logic [7:0]  RED_THRESH    = 8'd200,
   parameter logic [15:0] MIN_HITS      = 16'd512,
   parameter int          STABLE_FRAMES = 3
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iEnable,
   input  logic        iPix_En,
   input  logic [10:0] iX,
   input  logic [10:0] iY,
   input  logic [7:0]  iRed,
   output logic [2:0]  oPosition,
   output logic        oFrame_Done,
   output logic        oBusy
);

   localparam logic [10:0] X_LAST     = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST     = 11'(V_ACTIVE - 1);
   localparam logic [2:0]  LAST_ZONE  = 3'(NUM_ZONES - 1);
   localparam logic [7:0]  STABLE_CNT = 8'(STABLE_FRAMES);

   scan_state_t state, state_nxt;

   logic        is_origin, is_last, is_hit;
   logic        cnt_clr, cnt_inc;
   logic [2:0]  scan_idx;
   logic [15:0] rd_cnt;
   logic [15:0] max_cnt, best_cnt;
   logic [2:0]  max_idx, best_idx;
   logic [2:0]  cand, prev_cand;
   logic [7:0]  match_cnt, match_nxt;

   assign is_origin = (iX == 11'd0) && (iY == 11'd0);
   assign is_last   = (iX == X_LAST) && (iY == Y_LAST);
   assign is_hit    = iPix_En && (iX < 11'(H_ACTIVE)) && (iY < 11'(V_ACTIVE))
                      && (iRed >= RED_THRESH);
   assign oBusy     = (state != IDLE);

   zone_counter u_zone_counter (
      .clk     (iCLK),
      .rst     (iRST),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .inc_idx (zone_of(iX)),
      .rd_idx  (scan_idx),
      .rd_cnt  (rd_cnt)
   );

   // State register.
   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and counter control; disable overrides everything.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (iEnable) state_nxt = WAIT_FS;
         end
         WAIT_FS: begin
            if (iPix_En && is_origin) begin
               cnt_clr   = 1'b1;
               cnt_inc   = is_hit;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            cnt_inc = is_hit;
            if (iPix_En && is_origin)    cnt_clr   = 1'b1;
            else if (iPix_En && is_last) state_nxt = DECIDE;
         end
         DECIDE: begin
            if (scan_idx == LAST_ZONE) state_nxt = FILTER;
         end
         FILTER:  state_nxt = WAIT_FS;
         default: state_nxt = IDLE;
      endcase
      if (!iEnable) begin
         state_nxt = IDLE;
         cnt_clr   = 1'b1;
         cnt_inc   = 1'b0;
      end
   end

   // Running argmax (strict > keeps the lowest index on ties) and filter step.
   always_comb begin
      best_cnt = max_cnt;
      best_idx = max_idx;
      if (scan_idx == 3'd0 || rd_cnt > max_cnt) begin
         best_cnt = rd_cnt;
         best_idx = scan_idx;
      end
      match_nxt = 8'd1;
      if (cand == prev_cand) begin
         match_nxt = (match_cnt >= STABLE_CNT) ? match_cnt : match_cnt + 8'd1;
      end
   end

   // Decision datapath, stability filter and outputs.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         scan_idx    <= '0;
         max_cnt     <= '0;
         max_idx     <= '0;
         cand        <= POS_NONE;
         prev_cand   <= POS_NONE;
         match_cnt   <= '0;
         oPosition   <= POS_NONE;
         oFrame_Done <= 1'b0;
      end else begin
         oFrame_Done <= 1'b0;
         if (state != DECIDE) scan_idx <= '0;
         if (!iEnable) begin
            prev_cand <= POS_NONE;
            match_cnt <= '0;
         end else begin
            case (state)
               DECIDE: begin
                  max_cnt  <= best_cnt;
                  max_idx  <= best_idx;
                  scan_idx <= scan_idx + 3'd1;
                  if (scan_idx == LAST_ZONE) begin
                     cand <= (best_cnt >= MIN_HITS) ? best_idx + 3'd1 : POS_NONE;
                  end
               end
               FILTER: begin
                  prev_cand   <= cand;
                  match_cnt   <= match_nxt;
                  oFrame_Done <= 1'b1;
                  if (match_nxt == STABLE_CNT) oPosition <= cand;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
